// File: rtl/gck_en_ctrl_pkg.sv
// Shared types and constants for the idle-detect clock-gate enable controller.
package gck_en_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HYST  = 2'd1,
    GATED = 2'd2
  } gck_en_state_e;

  // A programmed threshold of zero behaves as a threshold of one.
  localparam int THRESH_ZERO_SUB = 1;

endpackage

// File: rtl/gck_en_ctrl_if.sv
// Activity requests, control knobs and status outputs of the clock-gate enable controller.
interface gck_en_ctrl_if #(
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16
);
  logic              i_busy;
  logic              i_wake;
  logic              i_force_on;
  logic              i_disable;
  logic [CNT_W-1:0]  i_idle_thresh;
  logic              i_stat_clr;
  logic              o_clk_en;
  logic              o_clk_active;
  logic [1:0]        o_state;
  logic [STAT_W-1:0] o_gated_cycles;

  modport master (
    output i_busy, i_wake, i_force_on, i_disable, i_idle_thresh, i_stat_clr,
    input  o_clk_en, o_clk_active, o_state, o_gated_cycles
  );

  modport slave (
    input  i_busy, i_wake, i_force_on, i_disable, i_idle_thresh, i_stat_clr,
    output o_clk_en, o_clk_active, o_state, o_gated_cycles
  );
endinterface

// File: rtl/gck_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module gck_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gck_en_ctrl.sv
// Idle-detect controller driving a gck clk_en from a flop; gates after N idle cycles, wakes in one cycle.
module gck_en_ctrl
  import gck_en_ctrl_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int STAT_W     = 16,
  parameter bit RST_CLK_EN = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  gck_en_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] N_MIN = CNT_W'(THRESH_ZERO_SUB);
  localparam gck_en_state_e    RST_STATE = RST_CLK_EN ? RUN : GATED;

  gck_en_state_e    state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             clk_en_q;
  logic             act;
  logic [CNT_W-1:0] thr_n;
  logic [CNT_W:0]   cnt_inc;

  assign act     = bus.i_busy | bus.i_wake | bus.i_force_on | bus.i_disable;
  assign thr_n   = (bus.i_idle_thresh == '0) ? N_MIN : bus.i_idle_thresh;
  // One extra bit so cnt+1 cannot wrap before the compare.
  assign cnt_inc = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      HYST: begin
        if (act) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt_inc >= {1'b0, thr_n}) begin
          state_nxt = GATED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_inc[CNT_W-1:0];
        end
      end
      GATED: begin
        cnt_nxt = '0;
        if (act) begin
          state_nxt = RUN;
        end
      end
      default: begin
        // RUN, and the unused encoding which behaves as RUN.
        if (act) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (thr_n == N_MIN) begin
          state_nxt = GATED;
          cnt_nxt   = '0;
        end else begin
          state_nxt = HYST;
          cnt_nxt   = CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      clk_en_q <= RST_CLK_EN;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      clk_en_q <= (state_nxt != GATED);
    end
  end

  gck_sat_cnt #(
    .W (STAT_W)
  ) u_gated_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .clr (bus.i_stat_clr),
    .inc (state_q == GATED),
    .cnt (bus.o_gated_cycles)
  );

  assign bus.o_clk_en     = clk_en_q;
  assign bus.o_clk_active = clk_en_q;
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_gck_en_ctrl.sv
// Directed bench for gck_en_ctrl: gating latency, wake, hysteresis, threshold edge cases, statistics, reset.
module tb_gck_en_ctrl;
  import gck_en_ctrl_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 i_clk = ~i_clk;

  gck_en_ctrl_if #(.CNT_W(8), .STAT_W(16)) mif ();
  gck_en_ctrl_if #(.CNT_W(8), .STAT_W(4))  sif ();
  gck_en_ctrl_if #(.CNT_W(8), .STAT_W(16)) gif ();

  // Secondary instances follow the main stimulus.
  assign sif.i_busy        = mif.i_busy;
  assign sif.i_wake        = mif.i_wake;
  assign sif.i_force_on    = mif.i_force_on;
  assign sif.i_disable     = mif.i_disable;
  assign sif.i_idle_thresh = mif.i_idle_thresh;
  assign sif.i_stat_clr    = mif.i_stat_clr;
  assign gif.i_busy        = mif.i_busy;
  assign gif.i_wake        = mif.i_wake;
  assign gif.i_force_on    = mif.i_force_on;
  assign gif.i_disable     = mif.i_disable;
  assign gif.i_idle_thresh = mif.i_idle_thresh;
  assign gif.i_stat_clr    = mif.i_stat_clr;

  gck_en_ctrl #(.CNT_W(8), .STAT_W(16), .RST_CLK_EN(1'b1)) u_dut (
    .i_clk (i_clk), .i_rst (i_rst), .bus (mif.slave));
  gck_en_ctrl #(.CNT_W(8), .STAT_W(4), .RST_CLK_EN(1'b1)) u_dut_sat (
    .i_clk (i_clk), .i_rst (i_rst), .bus (sif.slave));
  gck_en_ctrl #(.CNT_W(8), .STAT_W(16), .RST_CLK_EN(1'b0)) u_dut_gated (
    .i_clk (i_clk), .i_rst (i_rst), .bus (gif.slave));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    i_rst             = 1'b1;
    mif.i_busy        = 1'b0;
    mif.i_wake        = 1'b0;
    mif.i_force_on    = 1'b0;
    mif.i_disable     = 1'b0;
    mif.i_idle_thresh = 8'd4;
    mif.i_stat_clr    = 1'b0;
    steps(2);
    check("rst_state",       mif.o_state, RUN);
    check("rst_clk_en",      mif.o_clk_en, 1);
    check("rst_active",      mif.o_clk_active, 1);
    check("rst_gated_cnt",   mif.o_gated_cycles, 0);
    check("rst0_state",      gif.o_state, GATED);
    check("rst0_clk_en",     gif.o_clk_en, 0);

    // Gate after 4 idle cycles with thresh=4.
    i_rst = 1'b0;
    step();
    check("idle1_state",     mif.o_state, HYST);
    check("idle1_en",        mif.o_clk_en, 1);
    steps(2);
    check("idle3_state",     mif.o_state, HYST);
    check("idle3_en",        mif.o_clk_en, 1);
    step();
    check("idle4_state",     mif.o_state, GATED);
    check("idle4_en",        mif.o_clk_en, 0);
    check("idle4_active",    mif.o_clk_active, 0);
    check("idle4_gcnt",      mif.o_gated_cycles, 0);
    step();
    check("gated_gcnt1",     mif.o_gated_cycles, 1);

    // One-cycle wake pulse.
    mif.i_wake = 1'b1;
    step();
    mif.i_wake = 1'b0;
    check("wake_state",      mif.o_state, RUN);
    check("wake_en",         mif.o_clk_en, 1);
    check("wake_gcnt",       mif.o_gated_cycles, 2);
    steps(3);
    check("rewake3_en",      mif.o_clk_en, 1);
    step();
    check("regate_en",       mif.o_clk_en, 0);
    check("regate_state",    mif.o_state, GATED);

    // Busy blip at idle count 3 restarts the count; act beats the threshold.
    mif.i_busy = 1'b1;
    step();
    mif.i_busy = 1'b0;
    check("busy_state",      mif.o_state, RUN);
    steps(3);
    check("blip_pre_state",  mif.o_state, HYST);
    mif.i_busy = 1'b1;
    step();
    mif.i_busy = 1'b0;
    check("act_wins_state",  mif.o_state, RUN);
    check("act_wins_en",     mif.o_clk_en, 1);
    steps(3);
    check("recount3_en",     mif.o_clk_en, 1);
    step();
    check("recount4_en",     mif.o_clk_en, 0);

    // Threshold zero behaves as one.
    mif.i_busy = 1'b1;
    step();
    mif.i_busy        = 1'b0;
    mif.i_idle_thresh = 8'd0;
    step();
    check("thr0_state",      mif.o_state, GATED);
    check("thr0_en",         mif.o_clk_en, 0);

    // Threshold lowered from 200 to 2 with cnt=5.
    mif.i_busy = 1'b1;
    step();
    mif.i_busy        = 1'b0;
    mif.i_idle_thresh = 8'd200;
    steps(5);
    check("thr200_state",    mif.o_state, HYST);
    check("thr200_en",       mif.o_clk_en, 1);
    mif.i_idle_thresh = 8'd2;
    step();
    check("thr_drop_state",  mif.o_state, GATED);
    check("thr_drop_en",     mif.o_clk_en, 0);

    // Statistic counter: clear, saturate the 4-bit copy, clear beats increment.
    mif.i_stat_clr = 1'b1;
    step();
    mif.i_stat_clr = 1'b0;
    check("clr_main",        mif.o_gated_cycles, 0);
    check("clr_sat",         sif.o_gated_cycles, 0);
    steps(14);
    check("sat14",           sif.o_gated_cycles, 14);
    step();
    check("sat15",           sif.o_gated_cycles, 15);
    steps(5);
    check("sat_hold",        sif.o_gated_cycles, 15);
    check("main20",          mif.o_gated_cycles, 20);
    mif.i_stat_clr = 1'b1;
    step();
    mif.i_stat_clr = 1'b0;
    check("clr_prio_main",   mif.o_gated_cycles, 0);
    check("clr_prio_sat",    sif.o_gated_cycles, 0);
    step();
    check("post_clr_inc",    mif.o_gated_cycles, 1);

    // Reset mid-HYST with cnt=3.
    mif.i_idle_thresh = 8'd4;
    mif.i_busy        = 1'b1;
    step();
    mif.i_busy = 1'b0;
    steps(3);
    check("pre_rst_state",   mif.o_state, HYST);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("mid_rst_state",   mif.o_state, RUN);
    check("mid_rst_en",      mif.o_clk_en, 1);
    check("mid_rst_gcnt",    mif.o_gated_cycles, 0);
    steps(3);
    check("post_rst3_en",    mif.o_clk_en, 1);
    step();
    check("post_rst4_en",    mif.o_clk_en, 0);

    // Disable from GATED holds RUN through long idle.
    mif.i_disable = 1'b1;
    step();
    check("dis_state",       mif.o_state, RUN);
    check("dis_en",          mif.o_clk_en, 1);
    for (int k = 0; k < 100; k++) begin
      step();
      check("dis_hold",      mif.o_clk_en, 1);
    end
    mif.i_disable = 1'b0;
    steps(3);
    check("undis3_en",       mif.o_clk_en, 1);
    step();
    check("undis4_en",       mif.o_clk_en, 0);

    // Force-on behaves like disable.
    mif.i_force_on = 1'b1;
    step();
    check("force_state",     mif.o_state, RUN);
    steps(10);
    check("force_hold",      mif.o_state, RUN);
    mif.i_force_on = 1'b0;
    steps(3);
    check("unforce3_en",     mif.o_clk_en, 1);
    step();
    check("unforce4_en",     mif.o_clk_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gck_en_ctrl.md
Name: gck_en_ctrl

Overview:
- Idle-detect clock-gate enable controller; sits directly upstream of the gck clock-gating cell and drives its clk_en.
- Runs on the free-running (ungated) clock, i.e. the same clock fed to gck clk_in.
- Monitors activity requests from the gated domain and its neighbours; deasserts the enable after a programmable number of consecutive idle cycles, with hysteresis.
- Reasserts the enable one cycle after any wake source. Counts gated cycles for power statistics.

Parameters:
- CNT_W, 8: width of idle threshold and hysteresis counter.
- STAT_W, 16: width of the saturating gated-cycle statistic counter.
- RST_CLK_EN, 1: 1 = clock enabled out of reset (state RUN); 0 = gated out of reset (state GATED).

Ports:
- i_clk  input  1  free-running clock; same net as gck clk_in.
- i_rst  input  1  reset; synchronous, active-high.
- i_busy  input  1  gated domain has work or is non-idle; level.
- i_wake  input  1  early wake from an upstream requester; level or pulse.
- i_force_on  input  1  software override; keeps the clock running.
- i_disable  input  1  gating disabled (debug/CSR); forces RUN.
- i_idle_thresh  input  CNT_W  consecutive idle cycles required before gating; 0 is treated as 1.
- i_stat_clr  input  1  synchronous clear of o_gated_cycles.
- o_clk_en  output  1  registered enable to gck clk_en.
- o_clk_active  output  1  equals o_clk_en; requesters hold i_busy/i_wake until they see it high.
- o_state  output  2  current FSM state (encoding in package).
- o_gated_cycles  output  STAT_W  saturating count of cycles spent in GATED.

Behaviour:
- Clock and reset: single clock i_clk. i_rst is synchronous, active-high.
- Reset values:
  - state = RUN if RST_CLK_EN else GATED.
  - o_clk_en = RST_CLK_EN; idle counter = 0; o_gated_cycles = 0.
- Definitions:
  - act = i_busy | i_wake | i_force_on | i_disable; idle = !act.
  - N = (i_idle_thresh == 0) ? 1 : i_idle_thresh.
- o_clk_en is a flop output: o_clk_en = (state != GATED). Nothing combinational reaches gck clk_en.
- FSM (states RUN, HYST, GATED):
  - RUN: act -> RUN, cnt = 0. idle and N == 1 -> GATED. idle and N > 1 -> HYST, cnt = 1.
  - HYST: act -> RUN, cnt = 0. idle and cnt + 1 >= N -> GATED, cnt = 0. Otherwise cnt = cnt + 1, stay in HYST.
  - GATED: act -> RUN (o_clk_en high in the next cycle; wake latency is exactly 1 cycle). idle -> stay in GATED.
- Gating latency: o_clk_en falls on the cycle after the N-th consecutive idle cycle.
- Simultaneous events: act wins over a threshold hit in the same cycle (go to RUN, not GATED).
- i_disable or i_force_on in any state: next state RUN. Both hold RUN while asserted.
- Threshold changed mid-HYST:
  - Comparison uses >=. If new N <= cnt + 1, the next idle cycle gates.
  - A larger N extends the count; cnt is never reset by a threshold change.
- Counter width: cnt is CNT_W bits. It cannot wrap, because it leaves HYST at N <= 2^CNT_W - 1.
- Statistic counter:
  - o_gated_cycles increments on every cycle with state == GATED and saturates at all-ones.
  - i_stat_clr clears it to 0 next cycle and has priority over the increment.
- Reset mid-operation (any state, any cnt): next cycle returns to reset values.
- Test mode is not handled here; gck test_en bypasses the gate independently.

Decomposition:
- Package gck_en_ctrl_pkg:
  - state enum gck_en_state_e: RUN = 2'd0, HYST = 2'd1, GATED = 2'd2; 2'd3 is unused and decodes to RUN.
  - Localparam for the threshold-zero substitution value (1).
- One sub-module, gck_sat_cnt: a saturating counter with sync clear and increment enable, parameterised by width.
  - Used for o_gated_cycles; reusable for other power statistics.
- Hysteresis counter and FSM stay in gck_en_ctrl.

Test Plan:
- Reset with RST_CLK_EN=1, thresh=4, all inputs 0:
  - idle counted from the cycle after reset release; o_clk_en falls exactly 4 cycles after the first idle cycle.
  - o_state goes RUN -> HYST -> GATED; o_gated_cycles increments from the next cycle.
- In GATED, pulse i_wake for 1 cycle -> o_clk_en = 1 on the next cycle, state RUN. With i_busy=0 it re-gates after 4 more idle cycles.
- thresh=4; idle 3 cycles, then i_busy=1 for 1 cycle -> back to RUN with cnt=0; o_clk_en never drops. A further 4 idle cycles are required to gate.
- thresh=0 -> gates after 1 idle cycle. thresh=200 reduced to 2 while cnt=5 in HYST -> GATED on the next idle cycle.
- Preload near saturation (STAT_W=4 variant), stay gated 20 cycles -> o_gated_cycles holds 15.
  - i_stat_clr asserted together with an increment -> reads 0 next cycle.
- Assert i_rst while in HYST with cnt=3 -> next cycle state=RUN, cnt=0, o_clk_en=1.
  - i_disable=1 while GATED -> RUN next cycle; stays RUN for 100 idle cycles.
